// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEFAULT_DEPTH   = 256;
  localparam int unsigned DEFAULT_LATENCY = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-indexed data store: synchronous write, combinational read.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder in front of a word-addressed data store.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              cap_en;
  logic              cap_we;
  logic [WORD_W-1:0] cap_addr, cap_wdata;
  logic              acc_we;
  logic [WORD_W-1:0] acc_addr;
  logic              acc_err;
  logic              ack_nxt, err_nxt;
  logic [WORD_W-1:0] rdata_nxt;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata_c;

  // IDLE responds from the live request (zero latency); later states from the captured copy
  always_comb begin
    acc_we   = (state == IDLE) ? we   : cap_we;
    acc_addr = (state == IDLE) ? addr : cap_addr;
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   ({2'b00, acc_addr[WORD_W-1:2]} >= WORD_W'(DEPTH));

  // Store commits on the edge that closes RESP, unless reset aborts it
  assign mem_we = (state == RESP) && acc_we && !acc_err && !rst;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (cap_addr[AW+1:2]),
    .wdata   (cap_wdata),
    .raddr   (acc_addr[AW+1:2]),
    .rdata_c (mem_rdata_c)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (req) begin
          cap_en = 1'b1;
          if (LATENCY > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Response outputs are registered so they line up with the RESP state
    if (state_nxt == RESP) begin
      ack_nxt = 1'b1;
      err_nxt = acc_err;
      if (!acc_we && !acc_err) rdata_nxt = mem_rdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
      rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) begin
      cap_we    <= we;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances against a transaction model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit bad(logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access captured at edge k answers after edge k+L, commits at edge k+L+1
  logic [31:0] mmem  [2][DEPTH];
  bit          mwr   [2][DEPTH];
  bit          mbusy [2];
  int          mresp [2];
  bit          mwe   [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  int          ecnt = 0;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    ecnt++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mbusy[d] = 1'b0;
      end else if (mbusy[d]) begin
        if (ecnt == mresp[d] + 1) begin
          if (mwe[d] && !bad(maddr[d])) begin
            mmem[d][maddr[d] / 4] = mwd[d];
            mwr[d][maddr[d] / 4]  = 1'b1;
          end
          mbusy[d] = 1'b0;
        end
      end else if (req[d]) begin
        mbusy[d] = 1'b1;
        mresp[d] = ecnt + lat(d);
        mwe[d]   = we[d];
        maddr[d] = addr[d];
        mwd[d]   = wdata[d];
      end
    end
    if (rst) chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        bit          e_ack, e_err, e_known;
        logic [31:0] e_rd;
        e_ack   = mbusy[d] && (ecnt == mresp[d]);
        e_err   = e_ack && bad(maddr[d]);
        e_known = 1'b1;
        e_rd    = 32'h0;
        if (e_ack && !mwe[d] && !e_err) begin
          e_known = mwr[d][maddr[d] / 4];
          e_rd    = mmem[d][maddr[d] / 4];
        end
        check32($sformatf("model_ack%0d", d), 32'(ack[d]), 32'(e_ack));
        check32($sformatf("model_err%0d", d), 32'(err[d]), 32'(e_err));
        if (e_known) check32($sformatf("model_rdata%0d", d), rdata[d], e_rd);
      end
    end
  end

  // One request on DUT d, held until ack; scramble perturbs addr/wdata after capture
  task automatic access(int d, bit wr, logic [31:0] a, logic [31:0] wd, bit scramble,
                        bit exp_err, logic [31:0] exp_rd, string name);
    int n;
    @(negedge clk);
    req[d] = 1'b1; we[d] = wr; addr[d] = a; wdata[d] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && n == 1) begin
        addr[d]  = $urandom;
        wdata[d] = $urandom;
      end
    end while (!ack[d] && n < 20);
    check32({name, "_ack"}, 32'(ack[d]), 32'd1);
    check32({name, "_lat"}, 32'(n), 32'(lat(d) + 1));
    check32({name, "_err"}, 32'(err[d]), 32'(exp_err));
    check32({name, "_rdata"}, rdata[d], exp_rd);
    req[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check32("reset_ack", 32'(ack[d]), 32'd0);
      check32("reset_err", 32'(err[d]), 32'd0);
      check32("reset_rdata", rdata[d], 32'd0);
    end
    rst = 1'b0;

    access(0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        "st10");
    access(0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF, "ld10");
    access(0, 1'b1, 32'h13,  32'h12345678, 1'b0, 1'b1, 32'h0,        "st13_misal");
    access(0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF, "ld10_after_misal");
    access(0, 1'b0, 32'h400, 32'h0,        1'b0, 1'b1, 32'h0,        "ld400_oor");
    access(0, 1'b1, 32'h3FC, 32'h0BADCAFE, 1'b0, 1'b0, 32'h0,        "st3fc_top");
    access(0, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b0, 32'h0BADCAFE, "ld3fc_top");
    access(0, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        "st20");

    // reset lands while the store to 0x20 is waiting
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h11111111;
    @(negedge clk);
    check32("abort_wait_ack", 32'(ack[0]), 32'd0);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check32("abort_rst_ack", 32'(ack[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check32("abort_no_ack", 32'(ack[0]), 32'd0);
    end
    access(0, 1'b0, 32'h20,  32'h0,        1'b0, 1'b0, 32'hA5A5A5A5, "ld20_after_abort");

    access(0, 1'b1, 32'h30,  32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        "st30_scramble");
    access(0, 1'b0, 32'h30,  32'h0,        1'b1, 1'b0, 32'hCAFEF00D, "ld30_scramble");

    access(1, 1'b1, 32'h0,   32'h11110000, 1'b0, 1'b0, 32'h0,        "l0_st0");
    access(1, 1'b1, 32'h4,   32'h22224444, 1'b0, 1'b0, 32'h0,        "l0_st4");

    // req held high: the zero-latency instance acks every second cycle
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    @(negedge clk);
    check32("b2b_ack0", 32'(ack[1]), 32'd1);
    check32("b2b_rdata0", rdata[1], 32'h11110000);
    addr[1] = 32'h4;
    @(negedge clk);
    check32("b2b_gap", 32'(ack[1]), 32'd0);
    @(negedge clk);
    check32("b2b_ack1", 32'(ack[1]), 32'd1);
    check32("b2b_rdata1", rdata[1], 32'h22224444);
    req[1] = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
